// File: rtl/circ2_switch_alloc_if.sv
// Flit handshake bundle between a router's five input channels, the allocator and its five outputs.
interface circ2_switch_alloc_if #(
  parameter int DATA_WIDTH = 37
);
  logic [5*DATA_WIDTH-1:0] in_data;
  logic [4:0]              in_valid;
  logic [4:0]              in_ready;
  logic [5*DATA_WIDTH-1:0] out_data;
  logic [4:0]              out_valid;
  logic [4:0]              out_ready;

  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/circ2_switch_alloc.sv
// Two-step circulant switch allocator: greedy shortest-path routing, per-output round-robin, one-flit slots.
// Optional CIRC2_ALLOC_CNT_EN adds saturating 16-bit forwarded-flit counters on flit_cnt.
module circ2_alloc_out #(
  parameter int DATA_WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [4:0]                 req,
  input  logic [4:0][DATA_WIDTH-1:0] in_data,
  input  logic                       out_ready,
  output logic [4:0]                 gnt,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid
`ifdef CIRC2_ALLOC_CNT_EN
  , output logic [15:0]              cnt
`endif
);
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            rr_q, rr_d;
  logic [2:0]            win;
  logic                  found, load;

  always_comb begin
    logic [3:0] idx;
    found = 1'b0;
    win   = 3'd0;
    idx   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      idx = 4'(rr_q) + 4'(i);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && req[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
    // Reset gating keeps in_ready low while rst_n is asserted.
    load   = rst_n && found && (!full_q || out_ready);
    gnt    = '0;
    if (load) gnt[win] = 1'b1;
    full_d = full_q && !out_ready;
    data_d = data_q;
    rr_d   = rr_q;
    if (load) begin
      full_d = 1'b1;
      data_d = in_data[win];
      rr_d   = (win == 3'd4) ? 3'd0 : win + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      rr_q   <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      rr_q   <= rr_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;

`ifdef CIRC2_ALLOC_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (full_q && out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
`endif
endmodule

module circ2_switch_alloc #(
  parameter int NODES_NUM  = 8,
  parameter int S0         = 1,
  parameter int S1         = 2,
  parameter int NODE_ID    = 0,
  parameter int DATA_WIDTH = 37,
  parameter int ADDR_W     = $clog2(NODES_NUM)
) (
  input logic clk,
  input logic rst_n,
  circ2_switch_alloc_if.slave bus
`ifdef CIRC2_ALLOC_CNT_EN
  , output logic [5*16-1:0] flit_cnt
`endif
);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0] N_W  = AW1'(NODES_NUM);
  localparam logic [AW1-1:0] ID_W = AW1'(NODE_ID);
  localparam logic [AW1-1:0] S1_W = AW1'(S1);

  if (S0 <= 0 || S0 >= S1 || S1 > NODES_NUM / 2) begin : g_bad_steps
    $error("circ2_switch_alloc: steps must satisfy 0 < S0 < S1 <= NODES_NUM/2");
  end

  logic [4:0][DATA_WIDTH-1:0] lane_data;
  logic [4:0][2:0]            route;
  logic [4:0][4:0]            req, gnt;
  logic [4:0][DATA_WIDTH-1:0] od;
  logic [4:0]                 ov;
  logic [4:0]                 in_ready_c;

  assign lane_data = bus.in_data;

  // Destination offset is taken in ADDR_W+1 bits so dst + N - id never wraps.
  always_comb begin : route_c
    logic [AW1-1:0] dst, d, e;
    for (int j = 0; j < 5; j++) begin
      dst = {1'b0, lane_data[j][ADDR_W-1:0]};
      d   = dst + N_W - ID_W;
      if (d >= N_W) d = d - N_W;
      e   = N_W - d;
      if (dst >= N_W || d == '0) route[j] = 3'd4;
      else if (d <= e)           route[j] = (d >= S1_W) ? 3'd1 : 3'd0;
      else                       route[j] = (e >= S1_W) ? 3'd2 : 3'd3;
    end
  end

  always_comb begin
    req        = '0;
    in_ready_c = '0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 5; j++) req[k][j] = bus.in_valid[j] && (route[j] == 3'(k));
      in_ready_c = in_ready_c | gnt[k];
    end
  end

`ifdef CIRC2_ALLOC_CNT_EN
  logic [4:0][15:0] cnt;
  assign flit_cnt = cnt;
`endif

  for (genvar k = 0; k < 5; k++) begin : g_out
    circ2_alloc_out #(.DATA_WIDTH(DATA_WIDTH)) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req[k]),
      .in_data   (lane_data),
      .out_ready (bus.out_ready[k]),
      .gnt       (gnt[k]),
      .out_data  (od[k]),
      .out_valid (ov[k])
`ifdef CIRC2_ALLOC_CNT_EN
      , .cnt     (cnt[k])
`endif
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = od;
  assign bus.out_valid = ov;
endmodule

// File: tb/tb_circ2_switch_alloc.sv
// Directed bench for circ2_switch_alloc: routing sweep, contention, backpressure, invalid dst, reset, counters.
module tb_circ2_switch_alloc;
  localparam int DW = 37;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  circ2_switch_alloc_if #(.DATA_WIDTH(DW)) bus ();
  circ2_switch_alloc_if #(.DATA_WIDTH(DW)) bus2 ();
`ifdef CIRC2_ALLOC_CNT_EN
  logic [79:0] flit_cnt, flit_cnt2;
`endif

  circ2_switch_alloc #(.NODES_NUM(8), .S0(1), .S1(2), .NODE_ID(0), .DATA_WIDTH(DW), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef CIRC2_ALLOC_CNT_EN
    , .flit_cnt(flit_cnt)
`endif
  );

  circ2_switch_alloc #(.NODES_NUM(8), .S0(1), .S1(2), .NODE_ID(0), .DATA_WIDTH(DW), .ADDR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef CIRC2_ALLOC_CNT_EN
    , .flit_cnt(flit_cnt2)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input int pl, input int dst, input int aw);
    return (DW'(pl) << aw) | DW'(dst);
  endfunction

  task automatic put(input int j, input logic [DW-1:0] v);
    bus.in_data[j*DW +: DW] = v;
  endtask
  task automatic put2(input int j, input logic [DW-1:0] v);
    bus2.in_data[j*DW +: DW] = v;
  endtask
  function automatic logic [DW-1:0] od(input int k);
    return bus.out_data[k*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] od2(input int k);
    return bus2.out_data[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sweep_port [8];
    int inv_dst [4];
    int inv_port [4];
    logic [DW-1:0] f;
    sweep_port = '{4, 0, 1, 1, 1, 2, 2, 3};
    inv_dst    = '{9, 15, 5, 3};
    inv_port   = '{4, 4, 2, 1};

    bus.in_data = '0;  bus.in_valid = '0;  bus.out_ready = 5'h1F;
    bus2.in_data = '0; bus2.in_valid = '0; bus2.out_ready = 5'h1F;

    // Reset state, with a pending request that must not be granted
    bus.in_valid = 5'h10;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    bus.in_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Routing sweep from input 4
    for (int d = 0; d < 8; d++) begin
      f = flit(16 + d, d, 3);
      put(4, f);
      bus.in_valid = 5'h10;
      #1;
      chk("sweep_in_ready", 64'(bus.in_ready), 64'h10);
      tick();
      bus.in_valid = '0;
      chk("sweep_out_valid", 64'(bus.out_valid), 64'(5'h1 << sweep_port[d]));
      chk("sweep_out_data", 64'(od(sweep_port[d])), 64'(f));
      tick();
    end
    chk("sweep_drained", 64'(bus.out_valid), 64'h0);

    // Contention on output 1: inputs 0,1,2 with dst=3
    bus.out_ready = 5'h02;
    put(0, flit(8'hA0, 3, 3)); put(1, flit(8'hA1, 3, 3)); put(2, flit(8'hA2, 3, 3));
    bus.in_valid = 5'h07;
    #1;
    chk("cont_gnt0", 64'(bus.in_ready), 64'h01);
    tick();
    bus.in_valid = 5'h06;
    #1;
    chk("cont_vld0", 64'(bus.out_valid), 64'h02);
    chk("cont_data0", 64'(od(1)), 64'(flit(8'hA0, 3, 3)));
    chk("cont_gnt1", 64'(bus.in_ready), 64'h02);
    tick();
    bus.in_valid = 5'h04;
    #1;
    chk("cont_data1", 64'(od(1)), 64'(flit(8'hA1, 3, 3)));
    chk("cont_gnt2", 64'(bus.in_ready), 64'h04);
    tick();
    bus.in_valid = '0;
    #1;
    chk("cont_data2", 64'(od(1)), 64'(flit(8'hA2, 3, 3)));
    tick();
    chk("cont_drained", 64'(bus.out_valid), 64'h0);
    // rr[1] is now 3: input 3 beats input 2
    put(2, flit(8'hB2, 3, 3)); put(3, flit(8'hB3, 3, 3));
    bus.in_valid = 5'h0C;
    #1;
    chk("cont_rr3", 64'(bus.in_ready), 64'h08);
    tick();
    bus.in_valid = 5'h04;
    #1;
    chk("cont_rr_data3", 64'(od(1)), 64'(flit(8'hB3, 3, 3)));
    chk("cont_rr_gnt2", 64'(bus.in_ready), 64'h04);
    tick();
    bus.in_valid = '0;
    #1;
    chk("cont_rr_data2", 64'(od(1)), 64'(flit(8'hB2, 3, 3)));
    tick();

    // Backpressure: input 0 streaming dst=2, output 1 stalled 3 cycles
    bus.out_ready = 5'h1D;
    put(0, flit(8'hC0, 2, 3));
    bus.in_valid = 5'h01;
    #1;
    chk("bp_first_gnt", 64'(bus.in_ready), 64'h01);
    tick();
    put(0, flit(8'hC1, 2, 3));
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_hold_vld", 64'(bus.out_valid), 64'h02);
      chk("bp_hold_data", 64'(od(1)), 64'(flit(8'hC0, 2, 3)));
      chk("bp_stall_rdy", 64'(bus.in_ready), 64'h00);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 5'h1F;
    #1;
    chk("bp_release_rdy", 64'(bus.in_ready), 64'h01);
    tick();
    put(0, flit(8'hC2, 2, 3));
    #1;
    chk("bp_data1", 64'(od(1)), 64'(flit(8'hC1, 2, 3)));
    chk("bp_vld1", 64'(bus.out_valid), 64'h02);
    tick();
    bus.in_valid = '0;
    #1;
    chk("bp_data2", 64'(od(1)), 64'(flit(8'hC2, 2, 3)));
    tick();
    chk("bp_drained", 64'(bus.out_valid), 64'h0);

    // Fill every slot, then reset asynchronously
    bus.out_ready = 5'h00;
    put(0, flit(8'hD0, 1, 3)); put(1, flit(8'hD1, 2, 3)); put(2, flit(8'hD2, 6, 3));
    put(3, flit(8'hD3, 7, 3)); put(4, flit(8'hD4, 0, 3));
    bus.in_valid = 5'h1F;
    #1;
    chk("fill_gnt_all", 64'(bus.in_ready), 64'h1F);
    tick();
    bus.in_valid = '0;
    #1;
    chk("fill_out_valid", 64'(bus.out_valid), 64'h1F);
    chk("fill_data2", 64'(od(2)), 64'(flit(8'hD2, 6, 3)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_out_data", 64'(|bus.out_data), 64'h0);
    put(1, flit(8'hF1, 3, 3)); put(3, flit(8'hF3, 3, 3));
    bus.in_valid = 5'h0A;
    bus.out_ready = 5'h1F;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("postrst_rr0", 64'(bus.in_ready), 64'h02);
    tick();
    bus.in_valid = 5'h08;
    #1;
    chk("postrst_next", 64'(bus.in_ready), 64'h08);
    tick();
    bus.in_valid = '0;
    tick();

    // Invalid and wide destinations on the ADDR_W=4 build
    for (int t = 0; t < 4; t++) begin
      f = flit(8'hE0 + t, inv_dst[t], 4);
      put2(0, f);
      bus2.in_valid = 5'h01;
      #1;
      chk("wide_in_ready", 64'(bus2.in_ready), 64'h01);
      tick();
      bus2.in_valid = '0;
      chk("wide_out_valid", 64'(bus2.out_valid), 64'(5'h1 << inv_port[t]));
      chk("wide_out_data", 64'(od2(inv_port[t])), 64'(f));
      tick();
    end

`ifdef CIRC2_ALLOC_CNT_EN
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    put(4, flit(8'h55, 7, 3));
    bus.in_valid = 5'h10;
    repeat (20) tick();
    bus.in_valid = '0;
    tick();
    chk("cnt_port3", 64'(flit_cnt[3*16 +: 16]), 64'd20);
    chk("cnt_others", 64'(|(flit_cnt & ~(80'hFFFF << 48))), 64'h0);
    force dut.g_out[3].u_out.cnt_q = 16'hFFFF;
    #1;
    release dut.g_out[3].u_out.cnt_q;
    bus.in_valid = 5'h10;
    tick();
    bus.in_valid = '0;
    tick();
    tick();
    chk("cnt_saturate", 64'(flit_cnt[3*16 +: 16]), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/circ2_switch_alloc.md
# circ2_switch_alloc

Per-node switch allocator and output stage for the two-step circulant NoC, with steps S0 and S1. It sits between a router's five input channels and its five output channels: four circulant links plus the local port. For each single-flit packet it computes the output port from the destination field using greedy shortest-path circulant routing. It then arbitrates each output round-robin among the requesting inputs and holds the winner in a one-flit output register under a valid/ready handshake. Output link ports 0–3 plug directly into the circulant connector's per-node port slots.

## Interface
- NODES_NUM, 8, number of nodes in the circulant.
- S0, 1, first circulant step.
- S1, 2, second circulant step; 0 < S0 < S1 <= NODES_NUM/2.
- NODE_ID, 0, index of this router (0..NODES_NUM-1).
- DATA_WIDTH, 37, flit width; the destination is held in bits [ADDR_W-1:0].
- ADDR_W, $clog2(NODES_NUM), width of the destination field.
- clk  input  1  single clock for the whole block; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  5*DATA_WIDTH  input flits; port j occupies [j*DATA_WIDTH+:DATA_WIDTH].
- in_valid  input  5  flit present on input j.
- in_ready  output  5  input j's flit is accepted this cycle.
- out_data  output  5*DATA_WIDTH  output flits, one per port.
- out_valid  output  5  output slot k holds a flit.
- out_ready  input  5  downstream accepts the flit on port k.
- flit_cnt  output  5*16  forwarded-flit counters; this port exists only with CIRC2_ALLOC_CNT_EN.

Port map:
- Port 0 goes to node +S0.
- Port 1 goes to node +S1.
- Port 2 goes to node −S1.
- Port 3 goes to node −S0.
- Port 4 is local.

## Operation
- Route computation, per input and purely combinational:
  - d = (dst − NODE_ID) mod NODES_NUM and e = NODES_NUM − d.
  - d == 0 → port 4.
  - d <= e and d >= S1 → port 1.
  - d <= e and d < S1 → port 0.
  - d > e and e >= S1 → port 2.
  - d > e otherwise → port 3.
  - dst >= NODES_NUM → port 4.
  - Modular arithmetic uses ADDR_W+1 bits, with no wrap error.
- Each output k has a one-flit slot, a full flag and a 3-bit round-robin pointer rr[k] in the range 0..4.
- Slot k can load when it is not full, or when it is full and out_ready[k]=1 (drain and refill in the same cycle).
- Arbitration for output k:
  - Requesters are the inputs with in_valid=1 whose route is k.
  - The winner is the first requester found searching from rr[k] upward, modulo 5.
  - When slot k can load, the winner gets in_ready=1 in the same cycle (combinational from in_valid and slot state).
  - On that clock edge the flit is latched, full is set, and rr[k] ← (winner+1) mod 5.
- Each input targets exactly one output, so in_ready has at most one source and inputs never conflict across outputs.
- An input that is not granted keeps in_valid and in_data stable; the block does not drop flits.
- Drain without refill: out_valid[k]=1 and out_ready[k]=1 with no grant clears full.
- U-turns are permitted: an input may be routed to the same-numbered output.
- Reset, including mid-operation: every full flag ← 0, so held flits are discarded. Also rr ← 0, out_valid ← 0, out_data ← 0, counters ← 0. in_ready is 0 while rst_n=0.

## Timing
- Latency: a flit accepted at edge n appears on out_valid/out_data in the cycle after edge n, i.e. one cycle.
- Throughput: one flit per output per cycle while out_ready is held at 1.
- in_ready depends combinationally on in_valid and out_ready; upstream valid must not depend on in_ready.
- out_valid and out_data come directly from registers; there is no combinational path from inputs to out_*.
- Simultaneous requests: one grant per output per cycle. Losers wait, and a loser is guaranteed service within 4 grants of its output.

## Configuration
- CIRC2_ALLOC_CNT_EN defined:
  - Adds a 16-bit counter per output, incremented on each out_valid & out_ready handshake.
  - Counters saturate at 16'hFFFF and are exposed on flit_cnt.
- CIRC2_ALLOC_CNT_EN undefined: no counters and no flit_cnt port; routing and arbitration behaviour is identical.

## Test plan
All scenarios use NODES_NUM=8, S0=1, S1=2, NODE_ID=0.
- Routing sweep: single flits from input 4 with dst 0..7 and out_ready=5'h1F → output ports 4, 0, 1, 1, 1, 2, 2, 3, each with out_valid one cycle after acceptance.
- Contention: inputs 0, 1 and 2 all with dst=3 in the same cycle, out_ready[1]=1 → grants in order 0, 1, 2 on consecutive cycles, rr[1]=3 afterwards, and out_data on port 1 in that order.
- Backpressure: out_ready[1]=0 for 3 cycles with input 0 streaming dst=2 →
  - First flit held with out_valid[1]=1.
  - in_ready[0]=0 for the remaining stall cycles.
  - After release, one flit per cycle with no loss or duplication.
- Invalid destination: dst=9 (ADDR_W=3 truncates it, so use an ADDR_W=4 build) → routed to port 4.
- Reset mid-operation: assert rst_n=0 while all slots are full → out_valid=0 immediately, asynchronously; after release the first grants start from rr=0.
- With CIRC2_ALLOC_CNT_EN: 20 flits to port 3 → flit_cnt[3*16+:16]=20 and the other counters 0; a forced preload to 16'hFFFF stays at 16'hFFFF.
